// File: rtl/multiword_adder_pkg.sv
// multiword_adder_pkg
//   Shared definitions for the sequential arithmetic blocks (multiword
//   adder today; serial multiplier and accumulator reuse the same control
//   encoding). Holds the three-state control encoding and a helper that
//   sizes slice-index counters.
//   No ports (package).
package multiword_adder_pkg;

    // Control states shared by the slice-serial arithmetic blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that walks 0..chunks-1; never narrower than 1 bit
    // so a single-slice build still has a legal index register.
    function automatic int idx_width(input int chunks);
        int w;
        w = $clog2(chunks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multiword_adder_adder.sv
// adder
//   Combinational WIDTH-bit ripple adder used as the slice datapath.
//   Ports:
//     a, b  [WIDTH-1:0]  addends
//     cin                carry in
//     s     [WIDTH-1:0]  sum
//     cout               carry out
module adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/multiword_adder.sv
// multiword_adder
//   Adds two WIDTH*CHUNKS-bit operands one WIDTH-bit slice per cycle through
//   a single adder instance, carrying the slice carry-out between cycles.
//   Ports:
//     clk, rst            rising-edge clock, synchronous active-high reset
//     in_valid/in_ready   operand handshake (accepted only in IDLE)
//     a, b, cin           operands, latched on accept
//     out_valid/out_ready result handshake (held in DONE)
//     s, cout             N-bit sum and final carry-out
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*CHUNKS-1:0] a,
    input  logic [WIDTH*CHUNKS-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*CHUNKS-1:0] s,
    output logic                    cout
);

    localparam int N     = WIDTH * CHUNKS;
    localparam int IDX_W = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     s_q, s_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_cout;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Slice select: only one WIDTH-bit ripple sits on the critical path.
    assign slice_a = a_q[idx_q*WIDTH +: WIDTH];
    assign slice_b = b_q[idx_q*WIDTH +: WIDTH];

    adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_sum),
        .cout(slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; in_ready is forced low during reset so nothing is
    // accepted on the edge that clears the machine.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: operand capture on accept, one slice per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        if (state_q == IDLE && accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            s_d[idx_q*WIDTH +: WIDTH] = slice_sum;
            carry_d                   = slice_cout;
            if (idx_q == LAST_IDX) begin
                cout_d = slice_cout;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Operand copies need no reset: they are always written before use.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_multiword_adder.sv
// tb_multiword_adder
//   Directed scenarios on WIDTH=4/CHUNKS=4 and WIDTH=8/CHUNKS=1 instances,
//   plus randomized handshake traffic on WIDTH=4 with CHUNKS 1, 3 and 8,
//   compared against a plain a+b+cin reference queue.
module tb_multiword_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // WIDTH=4, CHUNKS=4 instance
    logic        iv = 0, orr = 0, ci = 0;
    logic [15:0] a = 0, b = 0;
    logic        ir, ov, co;
    logic [15:0] s;

    multiword_adder #(.WIDTH(4), .CHUNKS(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .cin(ci), .out_valid(ov), .out_ready(orr), .s(s), .cout(co)
    );

    // WIDTH=8, CHUNKS=1 instance
    logic       iv8 = 0, orr8 = 0, ci8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       ir8, ov8, co8;
    logic [7:0] s8;

    multiword_adder #(.WIDTH(8), .CHUNKS(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(ci8), .out_valid(ov8), .out_ready(orr8), .s(s8), .cout(co8)
    );

    // Random-regression instances: WIDTH=4, CHUNKS = 1, 3, 8
    logic        r_iv [3];
    logic        r_or [3];
    logic        r_ci [3];
    logic [31:0] r_a  [3];
    logic [31:0] r_b  [3];
    logic        ir_r1, ov_r1, co_r1, ir_r3, ov_r3, co_r3, ir_r8, ov_r8, co_r8;
    logic [3:0]  s_r1;
    logic [11:0] s_r3;
    logic [31:0] s_r8;

    multiword_adder #(.WIDTH(4), .CHUNKS(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid(r_iv[0]), .in_ready(ir_r1),
        .a(r_a[0][3:0]), .b(r_b[0][3:0]), .cin(r_ci[0]), .out_valid(ov_r1),
        .out_ready(r_or[0]), .s(s_r1), .cout(co_r1)
    );
    multiword_adder #(.WIDTH(4), .CHUNKS(3)) u_r3 (
        .clk(clk), .rst(rst), .in_valid(r_iv[1]), .in_ready(ir_r3),
        .a(r_a[1][11:0]), .b(r_b[1][11:0]), .cin(r_ci[1]), .out_valid(ov_r3),
        .out_ready(r_or[1]), .s(s_r3), .cout(co_r3)
    );
    multiword_adder #(.WIDTH(4), .CHUNKS(8)) u_r8 (
        .clk(clk), .rst(rst), .in_valid(r_iv[2]), .in_ready(ir_r8),
        .a(r_a[2]), .b(r_b[2]), .cin(r_ci[2]), .out_valid(ov_r8),
        .out_ready(r_or[2]), .s(s_r8), .cout(co_r8)
    );

    // Offer one operand set to the main instance and wait for out_valid.
    // lat = number of edges after the accepting edge until out_valid.
    task automatic run_add(input logic [15:0] x, input logic [15:0] y,
                           input logic c, output int lat);
        int guard;
        guard = 0;
        while (!ir && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a = x; b = y; ci = c; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        a = $urandom; b = $urandom; ci = $urandom_range(0, 1);
        lat = 0;
        while (!ov && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (ir !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake ir=%b ov=%b required ir=0 ov=0", ir, ov);
        end
        checks++;
        if (s !== 16'h0 || co !== 1'b0) begin
            failures++;
            $display("FAIL reset_result s=%h cout=%b required s=0000 cout=0", s, co);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%b required 1", ir);
        end
    endtask

    task automatic test_full_ripple();
        int lat;
        run_add(16'hFFFF, 16'h0001, 1'b0, lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL ripple_latency got=%0d required=4", lat);
        end
        checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            failures++;
            $display("FAIL ripple_sum s=%h cout=%b required s=0000 cout=1", s, co);
        end
        consume();
    endtask

    task automatic test_carry_in();
        int lat;
        run_add(16'h1234, 16'h4321, 1'b1, lat);
        checks++;
        if (s !== 16'h5556 || co !== 1'b0) begin
            failures++;
            $display("FAIL cin_sum s=%h cout=%b required s=5556 cout=0", s, co);
        end
        consume();
        run_add(16'h8000, 16'h8000, 1'b0, lat);
        checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            failures++;
            $display("FAIL msb_carry s=%h cout=%b required s=0000 cout=1", s, co);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_add(16'hA5C3, 16'h1F2E, 1'b1, lat);   // 0xC4F2, cout 0
        a = 16'h0F0F; b = 16'h7070; ci = 1'b0; iv = 1'b1;  // next: 0x7F7F
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov !== 1'b1 || ir !== 1'b0 || s !== 16'hC4F2 || co !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold bad_cycles=%0d required 0 (last ov=%b ir=%b s=%h cout=%b)",
                     bad, ov, ir, s, co);
        end
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release ov=%b ir=%b required ov=0 ir=1", ov, ir);
        end
        @(posedge clk); #1;   // pending operand accepted on this edge
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != 4 || s !== 16'h7F7F || co !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_next lat=%0d s=%h cout=%b required lat=4 s=7f7f cout=0",
                     lat, s, co);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a = 16'h1111; b = 16'h2222; ci = 1'b0; iv = 1'b1;
        @(posedge clk); #1;      // accepted, idx=0
        iv = 1'b0;
        @(posedge clk); #1;      // idx=1
        @(posedge clk); #1;      // idx=2
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov !== 1'b0 || s !== 16'h0 || co !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset ov=%b s=%h cout=%b required ov=0 s=0000 cout=0", ov, s, co);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir !== 1'b1) begin
            failures++;
            $display("FAIL midrun_ready in_ready=%b required 1", ir);
        end
        run_add(16'h00FF, 16'h0001, 1'b0, lat);
        checks++;
        if (s !== 16'h0100 || co !== 1'b0 || lat != 4) begin
            failures++;
            $display("FAIL midrun_fresh s=%h cout=%b lat=%0d required s=0100 cout=0 lat=4", s, co, lat);
        end
        consume();
    endtask

    task automatic test_single_chunk();
        int lat;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; iv8 = 1'b1;
        checks++;
        if (ir8 !== 1'b1) begin
            failures++;
            $display("FAIL w8_ready in_ready=%b required 1", ir8);
        end
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != 1 || s8 !== 8'hFF || co8 !== 1'b1) begin
            failures++;
            $display("FAIL w8_sum lat=%0d s=%h cout=%b required lat=1 s=ff cout=1", lat, s8, co8);
        end
        orr8 = 1'b1;
        @(posedge clk); #1;
        orr8 = 1'b0;
    endtask

    task automatic test_random(input int k, input int chunks, input int n);
        logic [63:0] mask;
        logic [63:0] expv;
        logic [63:0] q[$];
        int          sent, got, cyc, nbits;
        logic        ir_o, ov_o, co_o;
        logic [31:0] s_o;
        nbits = 4 * chunks;
        mask  = (64'd1 << nbits) - 64'd1;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < 20000) begin
            case (k)
                0:       begin ir_o = ir_r1; ov_o = ov_r1; co_o = co_r1; s_o = {28'd0, s_r1}; end
                1:       begin ir_o = ir_r3; ov_o = ov_r3; co_o = co_r3; s_o = {20'd0, s_r3}; end
                default: begin ir_o = ir_r8; ov_o = ov_r8; co_o = co_r8; s_o = s_r8; end
            endcase
            r_iv[k] = (sent < n) && ($urandom_range(0, 2) != 0);
            r_a[k]  = $urandom & mask[31:0];
            r_b[k]  = $urandom & mask[31:0];
            r_ci[k] = 1'($urandom_range(0, 1));
            r_or[k] = ($urandom_range(0, 3) != 0);
            if (ov_o && r_or[k]) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra chunks=%0d result s=%h with no pending operand", chunks, s_o);
                end else begin
                    expv = q.pop_front();
                    if ({32'd0, s_o} !== (expv & mask) || co_o !== expv[nbits]) begin
                        failures++;
                        $display("FAIL rand_sum chunks=%0d s=%h cout=%b required s=%h cout=%b",
                                 chunks, s_o, co_o, expv & mask, expv[nbits]);
                    end
                end
                got++;
            end
            if (r_iv[k] && ir_o) begin
                q.push_back(64'(r_a[k]) + 64'(r_b[k]) + 64'(r_ci[k]));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        r_iv[k] = 1'b0;
        r_or[k] = 1'b0;
        checks++;
        if (got != n || q.size() != 0) begin
            failures++;
            $display("FAIL rand_count chunks=%0d got=%0d pending=%0d required got=%0d pending=0",
                     chunks, got, q.size(), n);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            r_iv[i] = 1'b0; r_or[i] = 1'b0; r_ci[i] = 1'b0;
            r_a[i] = 32'd0; r_b[i] = 32'd0;
        end
        test_reset();
        test_full_ripple();
        test_carry_in();
        test_backpressure();
        test_reset_mid_run();
        test_single_chunk();
        test_random(0, 1, 334);
        test_random(1, 3, 333);
        test_random(2, 8, 333);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
